// File: rtl/mips_pkg.sv
// Shared encodings, state enum and sizing for the HI/LO multiply/divide unit.
package mips_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DW       = 2 * XLEN;
    localparam int unsigned MD_ITER  = 32;
    localparam int unsigned MD_CNT_W = $clog2(MD_ITER);

    typedef enum logic [1:0] {
        SEL_RS   = 2'b00,
        SEL_MUL  = 2'b01,
        SEL_DIV  = 2'b10,
        SEL_HOLD = 2'b11
    } hilo_sel_e;

    typedef enum logic [1:0] {
        RF_NONE = 2'b00,
        RF_MUL  = 2'b01,
        RF_HI   = 2'b10,
        RF_LO   = 2'b11
    } rf_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } md_state_e;

    // Operation captured at issue
    typedef struct packed {
        logic            is_mul;
        logic            sgn;
        logic            neg;
        logic            mul_only;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } md_op_t;

    // Magnitude of a value that is signed only when sgn is set
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? (~x + XLEN'(1)) : x;
    endfunction

endpackage

// File: rtl/hilo_div_iter.sv
// Restoring divider datapath on magnitudes with quotient/remainder sign fixup.
module hilo_div_iter
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            sgn,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient_c,
    output logic [XLEN-1:0] remainder_c
);

    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvs;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (load) begin
            rem   <= '0;
            quo   <= mag(dividend, sgn);
            dvs   <= mag(divisor, sgn);
            neg_q <= sgn & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_r <= sgn & dividend[XLEN-1];
        end else if (step) begin
            // Borrow out of the trial subtract means the divisor did not fit
            if (!diff[XLEN]) begin
                rem <= diff[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
                rem <= shifted[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b0};
            end
        end
    end

    // Quotient truncates toward zero; remainder follows the dividend's sign
    assign quotient_c  = neg_q ? (~quo + XLEN'(1)) : quo;
    assign remainder_c = neg_r ? (~rem + XLEN'(1)) : rem;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit with pipeline stall; HILO_FAST_MUL_EN selects a
// single-cycle multiplier instead of the iterative shift-add one.
module hilo_muldiv_unit
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [1:0]      multiply,
    input  logic [1:0]      divide,
    input  logic [1:0]      HI_sel,
    input  logic [1:0]      LO_sel,
    input  logic [1:0]      MultoRF,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] rf_data,
    output logic            busy,
    output logic            stall
);

    md_state_e             state;
    md_op_t                op;
    logic [MD_CNT_W-1:0]   cnt;
    logic [DW-1:0]         prod;
    logic [DW-1:0]         prod_fix;
    logic [XLEN:0]         add_sum;
    logic [XLEN-1:0]       mul_res;
    logic [XLEN-1:0]       quotient_c;
    logic [XLEN-1:0]       remainder_c;
    logic                  start_req;
    logic                  mul_req;
    logic                  div_load;
    logic                  hilo_access;

    assign mul_req     = multiply[1];
    assign start_req   = multiply[1] | divide[1];
    assign div_load    = (state == IDLE) && instr_valid && !mul_req && divide[1];
    assign hilo_access = start_req || (HI_sel == SEL_RS) || (LO_sel == SEL_RS) || (MultoRF != RF_NONE);

    assign stall = rst_n && instr_valid && (busy ? hilo_access : start_req);

    assign add_sum  = {1'b0, prod[DW-1:XLEN]} + {1'b0, mag(op.a, op.sgn)};
    assign prod_fix = op.neg ? (~prod + DW'(1)) : prod;

    hilo_div_iter u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (div_load),
        .step        (state == DIV),
        .sgn         (divide[0]),
        .dividend    (rs_data),
        .divisor     (rt_data),
        .quotient_c  (quotient_c),
        .remainder_c (remainder_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            op      <= '0;
            prod    <= '0;
            hi      <= '0;
            lo      <= '0;
            mul_res <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid && HI_sel == SEL_RS) hi <= rs_data;
                    if (instr_valid && LO_sel == SEL_RS) lo <= rs_data;
                    if (instr_valid && start_req) begin
                        op.is_mul   <= mul_req;
                        op.sgn      <= mul_req ? multiply[0] : divide[0];
                        op.neg      <= (mul_req ? multiply[0] : divide[0]) &
                                       (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
                        op.mul_only <= mul_req && (HI_sel == SEL_HOLD) && (LO_sel == SEL_HOLD);
                        op.a        <= rs_data;
                        op.b        <= rt_data;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        if (mul_req) begin
`ifdef HILO_FAST_MUL_EN
                            prod  <= DW'(mag(rs_data, multiply[0])) * DW'(mag(rt_data, multiply[0]));
                            state <= FIX;
`else
                            prod  <= {XLEN'(0), mag(rt_data, multiply[0])};
                            state <= MUL;
`endif
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                MUL: begin
                    // Shift-add step: add multiplicand on the multiplier's LSB, shift right
                    prod <= prod[0] ? {add_sum, prod[XLEN-1:1]} : {1'b0, prod[DW-1:1]};
                    cnt  <= cnt + MD_CNT_W'(1);
                    if (cnt == MD_CNT_W'(MD_ITER - 1)) state <= FIX;
                end
                DIV: begin
                    if (op.b == '0) begin
                        hi    <= op.a;
                        lo    <= '1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + MD_CNT_W'(1);
                        if (cnt == MD_CNT_W'(MD_ITER - 1)) state <= FIX;
                    end
                end
                FIX: begin
                    if (op.is_mul) begin
                        mul_res <= prod_fix[XLEN-1:0];
                        if (!op.mul_only) begin
                            hi <= prod_fix[DW-1:XLEN];
                            lo <= prod_fix[XLEN-1:0];
                        end
                    end else begin
                        hi <= remainder_c;
                        lo <= quotient_c;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rf_data = '0;
        case (MultoRF)
            RF_MUL:  rf_data = mul_res;
            RF_HI:   rf_data = hi;
            RF_LO:   rf_data = lo;
            default: rf_data = '0;
        endcase
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit; define HILO_FAST_MUL_EN to check the 1-cycle multiply build.
module tb_hilo_muldiv_unit;

`ifdef HILO_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [1:0]  multiply;
    logic [1:0]  divide;
    logic [1:0]  HI_sel;
    logic [1:0]  LO_sel;
    logic [1:0]  MultoRF;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rf_data;
    logic        busy;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    hilo_muldiv_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .multiply    (multiply),
        .divide      (divide),
        .HI_sel      (HI_sel),
        .LO_sel      (LO_sel),
        .MultoRF     (MultoRF),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .hi          (hi),
        .lo          (lo),
        .rf_data     (rf_data),
        .busy        (busy),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [1:0] d,
                         input logic [1:0] hs, input logic [1:0] ls, input logic [1:0] rf,
                         input logic [31:0] a, input logic [31:0] b);
        instr_valid = v;
        multiply    = m;
        divide      = d;
        HI_sel      = hs;
        LO_sel      = ls;
        MultoRF     = rf;
        rs_data     = a;
        rt_data     = b;
    endtask

    task automatic drive_idle();
        drive(1'b0, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 32'h0, 32'h0);
    endtask

    // Issue one start for a single cycle, then count the cycles busy stays high
    task automatic run_op(input string tag, input logic [1:0] m, input logic [1:0] d,
                          input logic [1:0] hs, input logic [1:0] ls,
                          input logic [31:0] a, input logic [31:0] b, input int lat);
        int cyc;
        @(negedge clk);
        drive(1'b1, m, d, hs, ls, 2'b00, a, b);
        #1 check_eq({tag, " issue_stall"}, 32'(stall), 32'd1);
        @(negedge clk);
        drive_idle();
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check_eq({tag, " busy_cycles"}, 32'(cyc), 32'(lat));
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        check_eq("reset hi", hi, 32'h0);
        check_eq("reset lo", lo, 32'h0);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        MultoRF = 2'b01;
        #1 check_eq("reset mul_res", rf_data, 32'h0);
        MultoRF = 2'b00;

        // mult -3 * 7
        run_op("mult", 2'b11, 2'b00, 2'b01, 2'b01, 32'hFFFF_FFFD, 32'd7, MUL_LAT);
        check_eq("mult hi", hi, 32'hFFFF_FFFF);
        check_eq("mult lo", lo, 32'hFFFF_FFEB);

        // multu max * max
        run_op("multu", 2'b10, 2'b00, 2'b01, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        check_eq("multu hi", hi, 32'hFFFF_FFFE);
        check_eq("multu lo", lo, 32'h0000_0001);

        // divu 100 / 7
        run_op("divu", 2'b00, 2'b10, 2'b10, 2'b10, 32'd100, 32'd7, DIV_LAT);
        check_eq("divu lo", lo, 32'd14);
        check_eq("divu hi", hi, 32'd2);

        // div -7 / 2
        run_op("div", 2'b00, 2'b11, 2'b10, 2'b10, 32'hFFFF_FFF9, 32'd2, DIV_LAT);
        check_eq("div lo", lo, 32'hFFFF_FFFD);
        check_eq("div hi", hi, 32'hFFFF_FFFF);

        // divide by zero finishes after one busy cycle
        run_op("div0", 2'b00, 2'b11, 2'b10, 2'b10, 32'd5, 32'd0, 1);
        check_eq("div0 hi", hi, 32'd5);
        check_eq("div0 lo", lo, 32'hFFFF_FFFF);

        // most negative / -1
        run_op("divovf", 2'b00, 2'b11, 2'b10, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT);
        check_eq("divovf lo", lo, 32'h8000_0000);
        check_eq("divovf hi", hi, 32'h0);

        // mthi / mtlo from idle, then mul-only leaves them alone
        @(negedge clk);
        drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 32'd1, 32'd0);
        #1 check_eq("mthi stall", 32'(stall), 32'd0);
        @(negedge clk);
        drive(1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 32'd2, 32'd0);
        @(negedge clk);
        drive_idle();
        check_eq("mthi hi", hi, 32'd1);
        check_eq("mtlo lo", lo, 32'd2);
        run_op("mul", 2'b11, 2'b00, 2'b11, 2'b11, 32'd6, 32'd7, MUL_LAT);
        MultoRF = 2'b01;
        #1 check_eq("mul rf_data", rf_data, 32'd42);
        MultoRF = 2'b10;
        #1 check_eq("mul rf hi", rf_data, 32'd1);
        MultoRF = 2'b11;
        #1 check_eq("mul rf lo", rf_data, 32'd2);
        MultoRF = 2'b00;
        #1 check_eq("rf none", rf_data, 32'd0);

        // mthi / mfhi during a busy mult stall until commit
        @(negedge clk);
        drive(1'b1, 2'b11, 2'b00, 2'b01, 2'b01, 2'b00, 32'd2, 32'd3);
        @(negedge clk);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            if (cyc % 2 == 0) drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 32'h0000_ABCD, 32'd0);
            else              drive(1'b1, 2'b00, 2'b00, 2'b11, 2'b11, 2'b10, 32'd0, 32'd0);
            #1 check_eq("busy stall", 32'(stall), 32'd1);
            check_eq("busy hi held", hi, 32'd1);
            cyc++;
            @(negedge clk);
        end
        check_eq("stallmult busy_cycles", 32'(cyc), 32'(MUL_LAT));
        drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 32'h0000_ABCD, 32'd0);
        #1 check_eq("post stall", 32'(stall), 32'd0);
        check_eq("commit hi", hi, 32'd0);
        check_eq("commit lo", lo, 32'd6);
        @(negedge clk);
        drive_idle();
        check_eq("late mthi hi", hi, 32'h0000_ABCD);

        // reset in the middle of a divide
        drive(1'b1, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 32'd100, 32'd7);
        @(negedge clk);
        drive_idle();
        repeat (9) @(negedge clk);
        check_eq("middiv busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort hi", hi, 32'h0);
        check_eq("abort lo", lo, 32'h0);
        check_eq("abort busy", 32'(busy), 32'd0);
        check_eq("abort stall", 32'(stall), 32'd0);
        MultoRF = 2'b01;
        #1 check_eq("abort mul_res", rf_data, 32'h0);
        MultoRF = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mult2", 2'b11, 2'b00, 2'b01, 2'b01, 32'hFFFF_FFFD, 32'd7, MUL_LAT);
        check_eq("mult2 hi", hi, 32'hFFFF_FFFF);
        check_eq("mult2 lo", lo, 32'hFFFF_FFEB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
